// File: rtl/movegen_position_tx.sv
// movegen_position_tx
// Holds a chess position as a 64 x 4-bit board and applies UCI-style moves to it.
// On request, the board streams out as 64 nibbles, square 0 first.
//
// Ports:
//   clk            clock; all logic runs on the rising edge
//   rst            synchronous, active-high reset; loads the start position
//   i_move_valid   apply-move pulse (accepted only while idle)
//   i_move_data    {promote[1:0], piece[2:0], from_r, from_f, takes[2:0], to_r, to_f}
//   i_send         request one position stream (accepted only while idle)
//   o_busy         high whenever the FSM is not idle
//   out_pos_*      nibble stream {colour(1=white), piece[2:0]} with sop/eop framing
//   out_wtp        1 = white to play
//   out_castle     castling rights {WK, WQ, BK, BQ}
//   out_ep         en-passant file, qualified by out_ep_valid
//
// Build option:
//   MOVEGEN_POSITION_TX_CASTLE_EN  track castling rights and move the rook when
//                                  the king castles; otherwise out_castle is 0.
//
// Piece codes: none=0, king=1, queen=2, rook=3, bishop=4, knight=5, pawn=6.
// Square index = rank*8 + file, i.e. {rank, file}.

module movegen_position_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_move_valid,
    input  logic [19:0] i_move_data,
    input  logic        i_send,
    output logic        o_busy,
    output logic        out_pos_valid,
    output logic        out_pos_sop,
    output logic        out_pos_eop,
    output logic [3:0]  out_pos_data,
    output logic        out_wtp,
    output logic [3:0]  out_castle,
    output logic [2:0]  out_ep,
    output logic        out_ep_valid
);

    localparam logic [2:0] PcNone   = 3'd0;
    localparam logic [2:0] PcKing   = 3'd1;
    localparam logic [2:0] PcQueen  = 3'd2;
    localparam logic [2:0] PcRook   = 3'd3;
    localparam logic [2:0] PcBishop = 3'd4;
    localparam logic [2:0] PcKnight = 3'd5;
    localparam logic [2:0] PcPawn   = 3'd6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StApply = 2'd1,
        StSend  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [5:0]  cnt_q, cnt_d;

    // Captured move; the takes field is informational and not stored.
    logic [1:0]  mv_promote_q, mv_promote_d;
    logic [2:0]  mv_piece_q, mv_piece_d;
    logic [5:0]  mv_from_q, mv_from_d;
    logic [5:0]  mv_to_q, mv_to_d;

    logic [3:0]  board_q [64];
    logic [3:0]  board_d [64];

    logic        wtp_q, wtp_d;
    logic [2:0]  ep_q, ep_d;
    logic        ep_valid_q, ep_valid_d;

    logic        pos_valid_q, pos_valid_d;
    logic        pos_sop_q, pos_sop_d;
    logic        pos_eop_q, pos_eop_d;
    logic [3:0]  pos_data_q, pos_data_d;

    logic unused_takes;
    assign unused_takes = ^i_move_data[8:6];

    // Start-position contents of one square.
    function automatic logic [3:0] start_sq(input logic [5:0] idx);
        logic [2:0] back;
        unique case (idx[2:0])
            3'd0, 3'd7: back = PcRook;
            3'd1, 3'd6: back = PcKnight;
            3'd2, 3'd5: back = PcBishop;
            3'd3:       back = PcQueen;
            default:    back = PcKing;
        endcase
        case (idx[5:3])
            3'd0:    start_sq = {1'b1, back};
            3'd1:    start_sq = {1'b1, PcPawn};
            3'd6:    start_sq = {1'b0, PcPawn};
            3'd7:    start_sq = {1'b0, back};
            default: start_sq = {1'b0, PcNone};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Move decode
    // ------------------------------------------------------------------
    logic [2:0] from_r, from_f, to_r, to_f;
    logic [2:0] promo_piece, put_piece, promo_rank;
    logic       is_pawn, two_step, ep_capture;
    logic [5:0] ep_sq;

    assign from_r     = mv_from_q[5:3];
    assign from_f     = mv_from_q[2:0];
    assign to_r       = mv_to_q[5:3];
    assign to_f       = mv_to_q[2:0];
    assign is_pawn    = (mv_piece_q == PcPawn);
    assign promo_rank = wtp_q ? 3'd7 : 3'd0;

    always_comb begin
        unique case (mv_promote_q)
            2'd0: promo_piece = PcQueen;
            2'd1: promo_piece = PcBishop;
            2'd2: promo_piece = PcRook;
            default: promo_piece = PcKnight;
        endcase
    end

    assign put_piece  = (is_pawn && (to_r == promo_rank)) ? promo_piece : mv_piece_q;
    // 4-bit compare so rank arithmetic cannot wrap.
    assign two_step   = is_pawn && (({1'b0, to_r} == {1'b0, from_r} + 4'd2) ||
                                    ({1'b0, from_r} == {1'b0, to_r} + 4'd2));
    // Diagonal pawn move onto an empty square is an en-passant capture; the
    // captured pawn sits beside the mover on the destination file.
    assign ep_capture = is_pawn && (from_f != to_f) && (board_q[mv_to_q] == 4'h0);
    assign ep_sq      = {from_r, to_f};

`ifdef MOVEGEN_POSITION_TX_CASTLE_EN
    logic [3:0] castle_q, castle_d;
    logic       is_king, king_two, castle_k, castle_qs;

    assign is_king   = (mv_piece_q == PcKing);
    assign king_two  = ({1'b0, to_f} == {1'b0, from_f} + 4'd2) ||
                       ({1'b0, from_f} == {1'b0, to_f} + 4'd2);
    assign castle_k  = is_king && king_two && (to_f == 3'd6);
    assign castle_qs = is_king && king_two && (to_f == 3'd2);
    assign out_castle = castle_q;
`else
    assign out_castle = 4'b0000;
`endif

    // ------------------------------------------------------------------
    // FSM and next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        mv_promote_d = mv_promote_q;
        mv_piece_d   = mv_piece_q;
        mv_from_d    = mv_from_q;
        mv_to_d      = mv_to_q;

        unique case (state_q)
            StIdle: begin
                if (i_move_valid) begin
                    mv_promote_d = i_move_data[19:18];
                    mv_piece_d   = i_move_data[17:15];
                    mv_from_d    = i_move_data[14:9];
                    mv_to_d      = i_move_data[5:0];
                    pend_d       = i_send;
                    state_d      = StApply;
                end else if (i_send) begin
                    cnt_d   = 6'd0;
                    state_d = StSend;
                end
            end
            StApply: begin
                pend_d = 1'b0;
                if (pend_q) begin
                    cnt_d   = 6'd0;
                    state_d = StSend;
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Board and side-state updates, only in APPLY.
    always_comb begin
        board_d    = board_q;
        wtp_d      = wtp_q;
        ep_d       = ep_q;
        ep_valid_d = ep_valid_q;
`ifdef MOVEGEN_POSITION_TX_CASTLE_EN
        castle_d   = castle_q;
`endif
        if (state_q == StApply) begin
            board_d[mv_from_q] = 4'h0;
            if (ep_capture) begin
                board_d[ep_sq] = 4'h0;
            end
`ifdef MOVEGEN_POSITION_TX_CASTLE_EN
            if (castle_k) begin
                board_d[{from_r, 3'd5}] = board_q[{from_r, 3'd7}];
                board_d[{from_r, 3'd7}] = 4'h0;
            end
            if (castle_qs) begin
                board_d[{from_r, 3'd3}] = board_q[{from_r, 3'd0}];
                board_d[{from_r, 3'd0}] = 4'h0;
            end
            if (is_king) begin
                if (wtp_q) castle_d[3:2] = 2'b00;
                else       castle_d[1:0] = 2'b00;
            end
            // Any traffic on a corner kills the matching right.
            if (mv_from_q == 6'd7  || mv_to_q == 6'd7)  castle_d[3] = 1'b0;
            if (mv_from_q == 6'd0  || mv_to_q == 6'd0)  castle_d[2] = 1'b0;
            if (mv_from_q == 6'd63 || mv_to_q == 6'd63) castle_d[1] = 1'b0;
            if (mv_from_q == 6'd56 || mv_to_q == 6'd56) castle_d[0] = 1'b0;
`endif
            board_d[mv_to_q] = {wtp_q, put_piece};
            wtp_d      = ~wtp_q;
            ep_valid_d = two_step;
            if (two_step) begin
                ep_d = from_f;
            end
        end
    end

    // Stream outputs are registered: nibble k leaves one cycle after cnt_q == k.
    always_comb begin
        pos_valid_d = (state_q == StSend);
        pos_sop_d   = (state_q == StSend) && (cnt_q == 6'd0);
        pos_eop_d   = (state_q == StSend) && (cnt_q == 6'd63);
        pos_data_d  = (state_q == StSend) ? board_q[cnt_q] : 4'h0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= 1'b0;
            cnt_q        <= 6'd0;
            mv_promote_q <= 2'd0;
            mv_piece_q   <= PcNone;
            mv_from_q    <= 6'd0;
            mv_to_q      <= 6'd0;
            wtp_q        <= 1'b1;
            ep_q         <= 3'd0;
            ep_valid_q   <= 1'b0;
            pos_valid_q  <= 1'b0;
            pos_sop_q    <= 1'b0;
            pos_eop_q    <= 1'b0;
            pos_data_q   <= 4'h0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            mv_promote_q <= mv_promote_d;
            mv_piece_q   <= mv_piece_d;
            mv_from_q    <= mv_from_d;
            mv_to_q      <= mv_to_d;
            wtp_q        <= wtp_d;
            ep_q         <= ep_d;
            ep_valid_q   <= ep_valid_d;
            pos_valid_q  <= pos_valid_d;
            pos_sop_q    <= pos_sop_d;
            pos_eop_q    <= pos_eop_d;
            pos_data_q   <= pos_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                board_q[i] <= start_sq(6'(i));
            end
        end else begin
            board_q <= board_d;
        end
    end

`ifdef MOVEGEN_POSITION_TX_CASTLE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            castle_q <= 4'b1111;
        end else begin
            castle_q <= castle_d;
        end
    end
`endif

    assign o_busy        = (state_q != StIdle);
    assign out_pos_valid = pos_valid_q;
    assign out_pos_sop   = pos_sop_q;
    assign out_pos_eop   = pos_eop_q;
    assign out_pos_data  = pos_data_q;
    assign out_wtp       = wtp_q;
    assign out_ep        = ep_q;
    assign out_ep_valid  = ep_valid_q;

endmodule

// File: doc/movegen_position_tx.md
MOVEGEN_POSITION_TX -- requirements
Module: movegen_position_tx

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all logic on posedge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: i_move_valid  in  1  apply move pulse; i_move_data  in  20  UCI move {promote[1:0], piece[2:0], from_r, from_f, takes[2:0], to_r, to_f}.
REQ-004 SHALL have ports: i_send  in  1  request one position stream; o_busy  out  1  high when not IDLE.
REQ-005 SHALL have ports: out_pos_valid, out_pos_sop, out_pos_eop  out  1 each; out_pos_data  out  4  {colour(1=white), piece[2:0]}.
REQ-006 SHALL have ports: out_wtp  out  1; out_castle  out  4  {WK,WQ,BK,BQ}; out_ep  out  3  ep file; out_ep_valid  out  1.

Function
REQ-007 SHALL hold a 64x4-bit board in registers; square index = rank*8+file; piece codes none=0, king=1, queen=2, rook=3, bishop=4, knight=5, pawn=6.
REQ-008 SHALL implement states IDLE, APPLY, SEND; IDLE->APPLY on i_move_valid; IDLE->SEND on i_send without i_move_valid; APPLY->SEND if a send is pending, else APPLY->IDLE; SEND->IDLE after nibble 63.
REQ-009 SHALL apply a move in APPLY (one cycle): clear from-square, write to-square with {out_wtp, piece}, toggle out_wtp.
REQ-010 SHALL write promotion piece (0 queen, 1 bishop, 2 rook, 3 knight) instead of pawn when a pawn reaches rank 7 (white) or rank 0 (black).
REQ-011 SHALL set out_ep_valid=1 and out_ep=from_f on a pawn move of two ranks; otherwise clear out_ep_valid on any applied move.
REQ-012 SHALL, for a pawn moving diagonally onto an empty square, clear the square at (from_r, to_f).
REQ-013 SHALL emit, in SEND, exactly 64 consecutive out_pos_valid cycles, nibble k = board square k, sop with k=0, eop with k=63; first nibble on cycle after SEND entry.
REQ-014 SHALL hold out_wtp, out_castle, out_ep, out_ep_valid stable throughout SEND.
REQ-015 SHALL ignore i_move_valid and i_send while o_busy=1.
REQ-016 SHALL, when i_move_valid and i_send coincide in IDLE, apply the move then stream the updated board.
REQ-017 SHALL drive out_pos_sop/eop/data to 0 when out_pos_valid=0.
REQ-018 SHALL perform no legality checking; the takes field is informational only.

Reset
REQ-019 SHALL, on rst, load start position: squares 0-7 = B,D,C,A,9,C,D,B; 8-15 = E; 16-47 = 0; 48-55 = 6; 56-63 = 3,5,4,2,1,4,5,3.
REQ-020 SHALL, on rst, set out_wtp=1, out_castle=4'b1111, out_ep_valid=0, out_ep=0, state IDLE, out_pos_valid=0, pending send cleared.
REQ-021 SHALL, on rst mid-SEND, drop out_pos_valid the next cycle with no eop issued.

Configuration
REQ-022 SHALL, with MOVEGEN_POSITION_TX_CASTLE_EN defined: a king moving two files also moves the corner rook (g-file: h->f; c-file: a->d); king move clears both own rights; a move from or to a1/h1/a8/h8 clears that right.
REQ-023 SHALL, without MOVEGEN_POSITION_TX_CASTLE_EN: king moves are plain moves, out_castle is constant 4'b0000 including after reset.

Verification
REQ-024 Reset, pulse i_send -> 64 valid cycles; nibble0=0xB, 4=0x9, 12=0xE, 30=0x0, 60=0x1, 63=0x3; sop@0, eop@63; wtp=1, castle=0xF (0x0 without macro).
REQ-025 From reset, move e2e4 (piece6, 1/4 -> 3/4) plus send in same cycle -> square12=0x0, 28=0xE; wtp=0, ep_valid=1, ep=4.
REQ-026 From reset, move e1g1 (piece1) -> with macro: sq4=0, 5=0xB, 6=0x9, 7=0, castle=0x3; without: sq4=0, 5=0xC, 6=0x9, 7=0xB.
REQ-027 From reset, move pawn a2->a8 promote=2 -> square56=0xB, square8=0x0.
REQ-028 Assert rst at nibble 20 of a send -> out_pos_valid low next cycle, no eop; next i_send restarts at nibble0 with start position.
REQ-029 i_send and i_move_valid pulsed during SEND -> ignored; exactly 64 nibbles, board unchanged.
